// File: rtl/conv_pkg.sv
// Shared types for the conv_node_mc window MAC: FSM state encoding and accumulator sizing.
package conv_pkg;

   typedef enum logic [1:0] {IDLE, BIAS, MAC, OUT} state_t;

   // Headroom of clog2(N+1) bits covers N full-scale products plus the shifted bias.
   function automatic int acc_width(input int word_size, input int n);
      return 2*word_size + $clog2(n+1);
   endfunction

endpackage

// File: rtl/conv_sat.sv
// Rescale the accumulator to the output format and clamp it to a signed word.
// Negative results are zeroed when CONV_NODE_MC_RELU_EN is defined.
module conv_sat #(
   parameter int WORD_SIZE = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 36
) (
   input  logic [ACC_W-1:0]     acc,
   output logic [WORD_SIZE-1:0] res
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

   logic signed [ACC_W-1:0] shifted;
   logic [WORD_SIZE-1:0]    sat;

   // Arithmetic shift floors toward minus infinity.
   assign shifted = $signed(acc) >>> FRAC_BITS;

   always_comb begin
      sat = shifted[WORD_SIZE-1:0];
      if (shifted > SAT_MAX)      sat = SAT_MAX[WORD_SIZE-1:0];
      else if (shifted < SAT_MIN) sat = SAT_MIN[WORD_SIZE-1:0];
   end

`ifdef CONV_NODE_MC_RELU_EN
   assign res = sat[WORD_SIZE-1] ? '0 : sat;
`else
   assign res = sat;
`endif

endmodule

// File: rtl/conv_node_mc.sv
// Multi-cycle convolution node: one bias cycle plus N serial MACs over a captured window,
// weights fetched from an external store. Optional ReLU via CONV_NODE_MC_RELU_EN.
module conv_node_mc
   import conv_pkg::*;
#(
   parameter  int WORD_SIZE     = 16,
   parameter  int FRAC_BITS     = 8,
   parameter  int KERNEL_HEIGHT = 3,
   parameter  int KERNEL_WIDTH  = 2,
   parameter  int CHANNELS      = 2,
   localparam int N             = CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH,
   localparam int AW            = $clog2(N+1),
   localparam int ACC_W         = acc_width(WORD_SIZE, N)
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [CHANNELS-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] data_i,
   output logic [AW-1:0]        weight_addr_o,
   input  logic [WORD_SIZE-1:0] weight_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [WORD_SIZE-1:0] data_o
);

   state_t                  state_q, state_d;
   logic [AW-1:0]           addr_d;
   logic [CHANNELS-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] win_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [WORD_SIZE-1:0]    x_sel, sat_res;
   logic signed [2*WORD_SIZE-1:0] prod;

   assign ready_o = (state_q == IDLE);

   // Weight order walks rows fastest within a column, columns within a channel.
   always_comb begin
      x_sel = '0;
      for (int c = 0; c < CHANNELS; c++)
         for (int r = 0; r < KERNEL_HEIGHT; r++)
            for (int col = 0; col < KERNEL_WIDTH; col++)
               if (int'(weight_addr_o) == c*KERNEL_HEIGHT*KERNEL_WIDTH + col*KERNEL_HEIGHT + r + 1)
                  x_sel = win_q[c][r][col];
   end

   assign prod = $signed(weight_i) * $signed(x_sel);

   always_comb begin
      state_d = state_q;
      addr_d  = weight_addr_o;
      case (state_q)
         IDLE: if (valid_i) begin
            state_d = BIAS;
            addr_d  = '0;
         end
         BIAS: begin
            state_d = MAC;
            addr_d  = AW'(1);
         end
         MAC: if (weight_addr_o == AW'(N)) begin
            state_d = OUT;
            addr_d  = '0;
         end else begin
            addr_d  = weight_addr_o + 1'b1;
         end
         OUT: if (valid_o && ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         weight_addr_o <= '0;
         win_q         <= '0;
         acc_q         <= '0;
         valid_o       <= 1'b0;
         data_o        <= '0;
      end else begin
         state_q       <= state_d;
         weight_addr_o <= addr_d;
         if (state_q == IDLE && valid_i) win_q <= data_i;
         if (state_q == BIAS)
            acc_q <= $signed({{(ACC_W-WORD_SIZE){weight_i[WORD_SIZE-1]}}, weight_i}) <<< FRAC_BITS;
         else if (state_q == MAC)
            acc_q <= acc_q + $signed({{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod});
         // First OUT cycle captures the result; it then holds until the handshake.
         if (state_q == OUT) begin
            if (!valid_o) begin
               valid_o <= 1'b1;
               data_o  <= sat_res;
            end else if (ready_i) begin
               valid_o <= 1'b0;
            end
         end
      end
   end

   conv_sat #(
      .WORD_SIZE (WORD_SIZE),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
   ) u_sat (
      .acc (acc_q),
      .res (sat_res)
   );

endmodule

// File: tb/tb_conv_node_mc.sv
// Directed bench for conv_node_mc (16-bit Q8, 2x3x2 window): table of windows plus
// hand-written sequences for backpressure, mid-MAC reset and back-to-back windows.
module tb_conv_node_mc;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [1:0][2:0][1:0][15:0] data_i;
   logic [3:0]  weight_addr_o;
   logic [15:0] weight_i;
   logic [15:0] data_o;
   logic [15:0] wmem [0:15];

   int ntests = 0;
   int nfail  = 0;

   assign weight_i = wmem[weight_addr_o];
   always #5 clk_i = ~clk_i;

   conv_node_mc dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .data_i        (data_i),
      .weight_addr_o (weight_addr_o),
      .weight_i      (weight_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .data_o        (data_o)
   );

   typedef struct {
      logic [15:0] dval;
      logic [15:0] wval;
      logic [15:0] bias;
      int          hot;       // >0: ramp data, weight 1.0 only at this address
      logic [15:0] exp_lin;
      logic [15:0] exp_relu;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic load(input logic [15:0] dval, input logic [15:0] wval,
                       input logic [15:0] bias, input int hot);
      for (int i = 0; i < 16; i++) wmem[i] = '0;
      wmem[0] = bias;
      for (int a = 1; a <= 12; a++)
         wmem[a] = (hot == 0) ? wval : ((a == hot) ? 16'h0100 : 16'h0000);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 3; r++)
            for (int col = 0; col < 2; col++)
               data_i[c][r][col] = (hot == 0) ? dval : 16'(16*(c*6 + r*2 + col + 1));
   endtask

   task automatic fill(input logic [15:0] v);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 3; r++)
            for (int col = 0; col < 2; col++)
               data_i[c][r][col] = v;
   endtask

   task automatic accept(input string tag);
      @(negedge clk_i);
      check({tag, "_ready_idle"}, 32'(ready_o), 32'd1);
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [15:0] exp);
      int n;
      n = 0;
      while (!valid_o && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd14);
      check({tag, "_data"}, 32'(data_o), 32'(exp));
   endtask

   task automatic release_out(input string tag);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
      check({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
      check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
   endtask

   function automatic logic [15:0] pick(input vec_t v);
`ifdef CONV_NODE_MC_RELU_EN
      return v.exp_relu;
`else
      return v.exp_lin;
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{16'h0100, 16'h0080, 16'h0040, 0,  16'h0640, 16'h0640};
      vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 0,  16'h7FFF, 16'h7FFF};
      vecs[2] = '{16'h0100, 16'hFF00, 16'h0000, 0,  16'hF400, 16'h0000};
      vecs[3] = '{16'h8000, 16'h7FFF, 16'h8000, 0,  16'h8000, 16'h0000};
      vecs[4] = '{16'h0001, 16'hFFFF, 16'h0000, 0,  16'hFFFF, 16'h0000};
      vecs[5] = '{16'h0001, 16'h0001, 16'h0000, 0,  16'h0000, 16'h0000};
      vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 2,  16'h0030, 16'h0030};
      vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 4,  16'h0020, 16'h0020};
      vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 5,  16'h0040, 16'h0040};
      vecs[9] = '{16'h0000, 16'h0000, 16'h0000, 12, 16'h00C0, 16'h00C0};

      fill(16'h0000);
      for (int i = 0; i < 16; i++) wmem[i] = '0;
      #3;
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_addr", 32'(weight_addr_o), 32'd0);
      check("rst_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      for (int v = 0; v < 10; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         load(vecs[v].dval, vecs[v].wval, vecs[v].bias, vecs[v].hot);
         accept(tag);
         check({tag, "_bias_addr"}, 32'(weight_addr_o), 32'd0);
         fill(16'hFFFF);   // window must already be captured
         wait_result(tag, pick(vecs[v]));
         release_out(tag);
      end

      // Backpressure: hold OUT for 5 cycles while valid_i pulses.
      load(16'h0100, 16'h0080, 16'h0040, 0);
      accept("hold");
      wait_result("hold", 16'h0640);
      fill(16'h0200);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         valid_i = (i % 2 == 0);
         @(posedge clk_i);
         #1;
         check($sformatf("hold%0d_valid", i), 32'(valid_o), 32'd1);
         check($sformatf("hold%0d_data", i), 32'(data_o), 32'h0640);
         check($sformatf("hold%0d_ready", i), 32'(ready_o), 32'd0);
      end
      valid_i = 1'b0;
      release_out("hold");

      // Reset during MAC cycle 6, then a clean window.
      load(16'h0100, 16'h0080, 16'h0040, 0);
      accept("rstmac");
      repeat (6) begin
         @(posedge clk_i);
         #1;
      end
      check("rstmac_addr6", 32'(weight_addr_o), 32'd6);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("rstmac_valid", 32'(valid_o), 32'd0);
      check("rstmac_data", 32'(data_o), 32'd0);
      check("rstmac_addr", 32'(weight_addr_o), 32'd0);
      check("rstmac_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      accept("postrst");
      wait_result("postrst", 16'h0640);
      release_out("postrst");

      // Back-to-back with ready_i high and valid_i held; second window uses new data.
      load(16'h0100, 16'h0080, 16'h0040, 0);
      ready_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      fill(16'h0200);
      wait_result("b2b_a", 16'h0640);
      @(posedge clk_i);
      #1;
      check("b2b_gap_valid", 32'(valid_o), 32'd0);
      check("b2b_gap_ready", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      check("b2b_b_accepted", 32'(ready_o), 32'd0);
      n = 0;
      while (!valid_o && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check("b2b_b_latency", 32'(n), 32'd14);
      check("b2b_b_data", 32'(data_o), 32'h0C40);
      valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("b2b_b_valid_drop", 32'(valid_o), 32'd0);
      ready_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/conv_node_mc.md
CONV_NODE_MC -- requirements
Module: conv_node_mc

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, signed fixed-point word width.
REQ-002 The block SHALL have parameter FRAC_BITS, default 8, fractional bits of data, weights and result.
REQ-003 The block SHALL have parameters KERNEL_HEIGHT, KERNEL_WIDTH and CHANNELS, defaults 3, 2 and 2, giving the window shape; N = CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH.
REQ-004 The block SHALL have port clk_i, input, width 1: the only clock, with all flops on its rising edge.
REQ-005 The block SHALL have port reset_n_i, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port valid_i, input, width 1: data_i holds a valid window.
REQ-007 The block SHALL have port ready_o, output, width 1: the block can accept a window.
REQ-008 The block SHALL have port data_i, input, [CHANNELS][KERNEL_HEIGHT][KERNEL_WIDTH][WORD_SIZE], carrying the signed input window.
REQ-009 The block SHALL have port weight_addr_o, output, width clog2(N+1): registered index into the external weight store.
REQ-010 The block SHALL have port weight_i, input, WORD_SIZE: the signed word at weight_addr_o, valid combinationally in the same cycle.
REQ-011 The block SHALL have port valid_o, output, width 1: data_o is valid.
REQ-012 The block SHALL have port ready_i, input, width 1: downstream accepts data_o.
REQ-013 The block SHALL have port data_o, output, WORD_SIZE: the signed result.

Function
REQ-014 The FSM SHALL have the states IDLE, BIAS, MAC and OUT, stored in a register.
REQ-015 ready_o SHALL equal (state==IDLE), and a window SHALL be accepted on a rising edge with valid_i & ready_o.
REQ-016 On acceptance the block SHALL register data_i internally and enter BIAS with weight_addr_o=0.
REQ-017 BIAS SHALL last one cycle and load the accumulator with weight_i sign-extended and shifted left by FRAC_BITS.
REQ-018 MAC SHALL last exactly N cycles, with weight_addr_o stepping 1..N and the accumulator adding weight_i*x[k] each cycle at full precision.
REQ-019 For address a=k+1, the element x[k] SHALL be data[c][row][col] with k = c*KERNEL_HEIGHT*KERNEL_WIDTH + col*KERNEL_HEIGHT + row.
REQ-020 The accumulator width SHALL be 2*WORD_SIZE+clog2(N+1), signed, and SHALL never overflow.
REQ-021 On leaving MAC the block SHALL register data_o = saturate(acc >>> FRAC_BITS) to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1], truncating toward minus infinity.
REQ-022 valid_o SHALL assert N+2 rising edges after the accepting edge and stay high, with data_o stable, until an edge with ready_i=1.
REQ-023 On OUT with ready_i=1 the FSM SHALL return to IDLE, with valid_o=0 next cycle.
REQ-024 valid_i SHALL be ignored outside IDLE, and data_i changes after acceptance SHALL NOT affect the result.
REQ-025 weight_addr_o SHALL be 0 outside BIAS and MAC.

Reset
REQ-026 reset_n_i=0 SHALL immediately force state=IDLE, valid_o=0, data_o=0, weight_addr_o=0 and the accumulator to 0, regardless of clock.
REQ-027 Reset asserted mid-BIAS, MAC or OUT SHALL discard the window, and the first window accepted after deassertion SHALL compute correctly.

Configuration
REQ-028 When macro CONV_NODE_MC_RELU_EN is defined, the saturated result SHALL pass through ReLU, so negative results give data_o=0.
REQ-029 When CONV_NODE_MC_RELU_EN is undefined, data_o SHALL be the signed saturated result, with no other behavioural difference.

Structure
REQ-030 Package conv_pkg SHALL hold the FSM state enum and an acc_width(WORD_SIZE,N) constant function.
REQ-031 Saturation and ReLU SHALL be in sub-module conv_sat (combinational; acc in, WORD_SIZE out, ReLU via the macro).

Verification (WORD_SIZE=16, FRAC_BITS=8, 3x2x2, N=12)
REQ-032 Test: data all 0x0100, weights 0x0080, bias 0x0040 -> data_o=0x0640, valid_o rises 14 edges after acceptance.
REQ-033 Test: data all 0x7FFF, weights 0x7FFF, bias 0x7FFF -> data_o=0x7FFF (positive saturation).
REQ-034 Test: data all 0x0100, weights 0xFF00, bias 0 -> data_o=0xF400 without RELU_EN, 0x0000 with it.
REQ-035 Test: ready_i low for 5 cycles in OUT -> valid_o held, data_o stable, ready_o low, valid_i pulses ignored.
REQ-036 Test: reset_n_i pulsed at MAC cycle 6 -> all outputs 0 immediately; next window of REQ-032 gives 0x0640.
REQ-037 Test: two back-to-back windows with ready_i tied high -> both results correct, second accepted the edge after IDLE is re-entered.
